// File: rtl/vga_pkg.sv
// Shared VGA timing constants and sync-tracker state encoding.
// Used by the sync receiver and the display generator.
package vga_pkg;

   localparam int H_TOTAL_D  = 800;
   localparam int H_START_D  = 144;
   localparam int H_ACTIVE_D = 640;
   localparam int V_TOTAL_D  = 525;
   localparam int V_START_D  = 35;
   localparam int V_ACTIVE_D = 480;

   localparam logic [9:0]  CNT_MAX  = 10'h3FF;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } vga_state_t;

endpackage

// File: rtl/vga_crc16.sv
// Combinational CRC-16-CCITT step over one 12-bit pixel, MSB first.
// Only instantiated by vga_sync_rx when VGA_RX_CRC_EN is defined.
module vga_crc16
   import vga_pkg::*;
(
   input  logic [15:0] crc,
   input  logic [11:0] data,
   output logic [15:0] crc_nx
);

   logic [15:0] c;

   // Bit-serial update unrolled across the 12 colour bits
   always_comb begin
      c = crc;
      for (int i = 11; i >= 0; i--) begin
         if (c[15] ^ data[i])
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         else
            c = {c[14:0], 1'b0};
      end
      crc_nx = c;
   end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: lock tracking, active-area coordinates, pixel capture.
// Optional frame CRC is built when VGA_RX_CRC_EN is defined.
module vga_sync_rx
   import vga_pkg::*;
#(
   parameter int H_TOTAL  = H_TOTAL_D,
   parameter int H_START  = H_START_D,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int V_TOTAL  = V_TOTAL_D,
   parameter int V_START  = V_START_D,
   parameter int V_ACTIVE = V_ACTIVE_D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_ce,
   input  logic        hs,
   input  logic        vs,
   input  logic [3:0]  r,
   input  logic [3:0]  g,
   input  logic [3:0]  b,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        de,
   output logic [11:0] pix_rgb,
   output logic        locked,
   output logic        frame_start,
   output logic        sync_err,
   output logic [15:0] frame_crc,
   output logic        crc_valid
);

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_OFF  = 10'(H_START);
   localparam logic [9:0]  V_OFF  = 10'(V_START);
   localparam logic [10:0] H_LO   = 11'(H_START);
   localparam logic [10:0] H_HI   = 11'(H_START + H_ACTIVE);
   localparam logic [10:0] V_LO   = 11'(V_START);
   localparam logic [10:0] V_HI   = 11'(V_START + V_ACTIVE);

   vga_state_t state, state_nx;
   logic       hs_q, vs_q;
   logic [9:0] hcnt, vcnt;
   logic       line_ok, line_ok_nx;
   logic       err_nx;
   logic       hs_fall, vs_fall;
   logic       h_bad, v_bad, sat;
   logic       h_act, v_act, act;

   assign hs_fall = pix_ce & hs_q & ~hs;
   assign vs_fall = pix_ce & vs_q & ~vs;
   assign h_bad   = hs_fall && (hcnt != H_LAST);
   assign v_bad   = vs_fall && (vcnt != V_LAST);
   assign sat     = pix_ce && ((hcnt == CNT_MAX) || (vcnt == CNT_MAX));
   assign h_act   = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
   assign v_act   = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
   assign act     = (state == LOCKED) && h_act && v_act;
   assign locked  = (state == LOCKED);

   // Sync history, sampled only on pixel strobes, for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_q <= 1'b1;
         vs_q <= 1'b1;
      end else if (pix_ce) begin
         hs_q <= hs;
         vs_q <= vs;
      end
   end

   // Saturating pixel and line counters, re-zeroed by sync falls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_ce) begin
         if (hs_fall)
            hcnt <= '0;
         else if (hcnt != CNT_MAX)
            hcnt <= hcnt + 10'd1;
         if (vs_fall)
            vcnt <= '0;
         else if (hs_fall && (vcnt != CNT_MAX))
            vcnt <= vcnt + 10'd1;
      end
   end

   // Lock state and per-frame line-length flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= SEARCH;
         line_ok <= 1'b1;
      end else begin
         state   <= state_nx;
         line_ok <= line_ok_nx;
      end
   end

   // Line check resolves first; the frame check sees its outcome
   always_comb begin
      state_nx   = state;
      line_ok_nx = line_ok;
      err_nx     = 1'b0;
      unique case (state)
         TRACK: begin
            if (h_bad)
               line_ok_nx = 1'b0;
         end
         LOCKED: begin
            if (h_bad || sat) begin
               err_nx   = 1'b1;
               state_nx = SEARCH;
            end
         end
         default: ;
      endcase
      if (vs_fall) begin
         unique case (state_nx)
            SEARCH:
               state_nx = TRACK;
            TRACK:
               state_nx = (line_ok_nx && !v_bad) ? LOCKED : SEARCH;
            LOCKED: begin
               if (v_bad) begin
                  err_nx   = 1'b1;
                  state_nx = SEARCH;
               end
            end
            default:
               state_nx = SEARCH;
         endcase
         line_ok_nx = 1'b1;
      end
   end

   // Registered pixel outputs and status pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         pix_rgb     <= '0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_start <= vs_fall;
         sync_err    <= err_nx;
         if (pix_ce) begin
            de <= act;
            if (act) begin
               x       <= hcnt - H_OFF;
               y       <= vcnt - V_OFF;
               pix_rgb <= {r, g, b};
            end
         end
      end
   end

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc, crc_nx;

   vga_crc16 u_crc (
      .crc    (crc),
      .data   ({r, g, b}),
      .crc_nx (crc_nx)
   );

   // Running CRC over active pixels, closed out on locked frame boundaries
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         crc       <= CRC_INIT;
         frame_crc <= '0;
         crc_valid <= 1'b0;
      end else begin
         crc_valid <= 1'b0;
         if (vs_fall) begin
            crc <= CRC_INIT;
            if (state == LOCKED) begin
               frame_crc <= crc;
               crc_valid <= 1'b1;
            end
         end else if (pix_ce && act) begin
            crc <= crc_nx;
         end
      end
   end
`else
   assign frame_crc = '0;
   assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a reduced timing raster.
// Covers lock, coordinates, line/saturation errors, mid-frame reset, CRC.
module tb_vga_sync_rx;
   import vga_pkg::*;

   localparam int H_T  = 20;
   localparam int H_S  = 5;
   localparam int H_A  = 10;
   localparam int V_T  = 10;
   localparam int V_S  = 2;
   localparam int V_A  = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_ce = 1'b0;
   logic        hs = 1'b1;
   logic        vs = 1'b1;
   logic [3:0]  r = '0;
   logic [3:0]  g = '0;
   logic [3:0]  b = '0;
   logic [9:0]  x, y;
   logic        de;
   logic [11:0] pix_rgb;
   logic        locked, frame_start, sync_err;
   logic [15:0] frame_crc;
   logic        crc_valid;

   int n_chk = 0;
   int n_errs = 0;
   int n_fs = 0;
   int n_se = 0;
   int n_cv = 0;
   logic [15:0] cap_crc = '0;
   logic [15:0] m_crc = 16'hFFFF;
   int se0, cv0;
   logic [15:0] ref10, ref11, cap12;

   vga_sync_rx #(
      .H_TOTAL (H_T), .H_START (H_S), .H_ACTIVE (H_A),
      .V_TOTAL (V_T), .V_START (V_S), .V_ACTIVE (V_A)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_ce      (pix_ce),
      .hs          (hs),
      .vs          (vs),
      .r           (r),
      .g           (g),
      .b           (b),
      .x           (x),
      .y           (y),
      .de          (de),
      .pix_rgb     (pix_rgb),
      .locked      (locked),
      .frame_start (frame_start),
      .sync_err    (sync_err),
      .frame_crc   (frame_crc),
      .crc_valid   (crc_valid)
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (frame_start === 1'b1) n_fs++;
      if (sync_err === 1'b1) n_se++;
      if (crc_valid === 1'b1) begin
         n_cv++;
         cap_crc = frame_crc;
      end
   end

   task automatic check(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
      n_chk++;
      assert (o === e) else begin
         n_errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] s,
                                           input logic [11:0] d);
      logic [16:0] t;
      t = {1'b0, s};
      for (int i = 11; i >= 0; i--) begin
         t = {t[15:0], 1'b0};
         if (t[16] ^ d[i]) t[15:0] = t[15:0] ^ 16'h1021;
      end
      return t[15:0];
   endfunction

   // One pixel: inputs set, strobe for one clk, three idle clks
   task automatic pix(input logic h, input logic v, input logic [11:0] c);
      @(negedge clk);
      hs = h;
      vs = v;
      {r, g, b} = c;
      pix_ce = 1'b1;
      @(negedge clk);
      pix_ce = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Lines l0..l1-1 of a raster; optional short line and output checks
   task automatic frame(input int l0, input int l1, input int short_l,
                        input bit chk, input bit zc);
      logic [11:0] c;
      logic [11:0] lc;
      logic [9:0]  lx, ly;
      bit ed, seen;
      int len;
      seen = 1'b0;
      lc = '0;
      lx = '0;
      ly = '0;
      for (int l = l0; l < l1; l++) begin
         len = (l == short_l) ? H_T - 1 : H_T;
         for (int p = 0; p < len; p++) begin
            c = zc ? 12'h000 : 12'(l * 37 + p * 11 + 929);
            pix((p < 2) ? 1'b0 : 1'b1, (l < 1) ? 1'b0 : 1'b1, c);
            ed = (p >= H_S + 1) && (p < H_S + H_A + 1) &&
                 (l >= V_S) && (l < V_S + V_A);
            if (l == 0 && p == 0) m_crc = 16'hFFFF;
            if (ed) m_crc = crc_upd(m_crc, c);
            if (chk) begin
               check("de", 32'(de), 32'(ed));
               if (ed) begin
                  lx = 10'(p - 1 - H_S);
                  ly = 10'(l - V_S);
                  lc = c;
                  seen = 1'b1;
               end
               if (ed || seen) begin
                  check("x", 32'(x), 32'(lx));
                  check("y", 32'(y), 32'(ly));
                  check("pix_rgb", 32'(pix_rgb), 32'(lc));
               end
            end
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_de", 32'(de), 32'd0);
      check("rst_xy", 32'({x, y}), 32'd0);
      check("rst_rgb", 32'(pix_rgb), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_pulses", 32'({frame_start, sync_err, crc_valid}), 32'd0);
      check("rst_frame_crc", 32'(frame_crc), 32'd0);
      check("rst_state", 32'(dut.state), 32'(SEARCH));
      check("rst_cnt", 32'({dut.hcnt, dut.vcnt}), 32'd0);
`ifdef VGA_RX_CRC_EN
      check("rst_crc_reg", 32'(dut.crc), 32'hFFFF);
`endif
      rst = 1'b1;
      repeat (3) pix(1'b1, 1'b1, 12'h000);

      // Acquire: track after first vs fall, lock after the second
      frame(0, V_T, -1, 1'b0, 1'b0);
      check("f1_locked", 32'(locked), 32'd0);
      check("f1_state", 32'(dut.state), 32'(TRACK));
      check("f1_fs", 32'(n_fs), 32'd1);
      frame(0, V_T, -1, 1'b1, 1'b0);
      check("f2_locked", 32'(locked), 32'd1);
      check("f2_fs", 32'(n_fs), 32'd2);
      check("f2_no_err", 32'(n_se), 32'd0);
      check("f2_last_x", 32'(x), 32'(H_A - 1));
      check("f2_last_y", 32'(y), 32'(V_A - 1));

      // One short line while locked
      se0 = n_se;
      frame(0, V_T, 4, 1'b0, 1'b0);
      check("short_err", 32'(n_se - se0), 32'd1);
      check("short_locked", 32'(locked), 32'd0);
      frame(0, V_T, -1, 1'b0, 1'b0);
      check("relock1_locked", 32'(locked), 32'd0);
      frame(0, V_T, -1, 1'b1, 1'b0);
      check("relock2_locked", 32'(locked), 32'd1);
      check("relock_err", 32'(n_se - se0), 32'd1);

      // Hold hs high past counter saturation
      se0 = n_se;
      repeat (1100) pix(1'b1, 1'b1, 12'h000);
      check("sat_hcnt", 32'(dut.hcnt), 32'h3FF);
      check("sat_err", 32'(n_se - se0), 32'd1);
      check("sat_state", 32'(dut.state), 32'(SEARCH));
      check("sat_locked", 32'(locked), 32'd0);
      frame(0, V_T, -1, 1'b0, 1'b0);
      frame(0, V_T, -1, 1'b1, 1'b0);
      check("f7_locked", 32'(locked), 32'd1);

      // Reset mid-frame, inside the active area
      frame(0, 6, -1, 1'b1, 1'b0);
      check("pre_rst_y", 32'(y), 32'd3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_de", 32'(de), 32'd0);
      check("mid_rst_xy", 32'({x, y}), 32'd0);
      check("mid_rst_rgb", 32'(pix_rgb), 32'd0);
      check("mid_rst_locked", 32'(locked), 32'd0);
      check("mid_rst_crc", 32'(frame_crc), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      se0 = n_se;
      frame(6, V_T, -1, 1'b0, 1'b0);
      check("post_rst_locked0", 32'(locked), 32'd0);
      frame(0, V_T, -1, 1'b0, 1'b0);
      check("post_rst_locked1", 32'(locked), 32'd0);
      check("post_rst_state", 32'(dut.state), 32'(TRACK));
      frame(0, V_T, -1, 1'b1, 1'b0);
      check("post_rst_locked2", 32'(locked), 32'd1);
      ref10 = m_crc;

      // Frame CRC: one coloured frame, then two all-zero frames
      cv0 = n_cv;
      frame(0, V_T, -1, 1'b1, 1'b1);
      ref11 = m_crc;
      frame(0, V_T, -1, 1'b1, 1'b1);
`ifdef VGA_RX_CRC_EN
      check("crc_f11_count", 32'(n_cv - cv0), 32'd2);
      check("crc_f11", 32'(cap_crc), 32'(ref11));
      cap12 = cap_crc;
      pix(1'b0, 1'b0, 12'h000);
      check("crc_f12_count", 32'(n_cv - cv0), 32'd3);
      check("crc_f12", 32'(cap_crc), 32'(m_crc));
      check("crc_same", 32'(cap_crc), 32'(cap12));
      check("crc_f10_ne_zero", 32'(ref10 != ref11), 32'd1);
`else
      pix(1'b0, 1'b0, 12'h000);
      check("crc_off_valid", 32'(n_cv - cv0), 32'd0);
      check("crc_off_value", 32'(frame_crc), 32'd0);
`endif
      check("crc_no_err", 32'(n_se - se0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_errs);
      $finish;
   end

endmodule

// File: doc/vga_sync_rx.md
VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
REQ-001 Parameter H_TOTAL, 800, pixel clocks per line.
REQ-002 Parameter H_START, 144, hs-fall-to-first-active-pixel offset (sync 96 + back porch 48).
REQ-003 Parameter H_ACTIVE, 640, active pixels per line.
REQ-004 Parameter V_TOTAL, 525, lines per frame.
REQ-005 Parameter V_START, 35, vs-fall-to-first-active-line offset (sync 2 + back porch 33).
REQ-006 Parameter V_ACTIVE, 480, active lines per frame.
REQ-007 clk  input  1  system clock, 100 MHz.
REQ-008 rst  input  1  reset; asynchronous, active-low.
REQ-009 pix_ce  input  1  one-clk pixel strobe; all sampling and counting occurs only on clk edges with pix_ce=1.
REQ-010 hs, vs  input  1 each  active-low sync, synchronous to clk.
REQ-011 r, g, b  input  4 each  pixel colour.
REQ-012 x, y  output  10 each  active-area coordinates of the current pixel.
REQ-013 de  output  1  active-area pixel valid.
REQ-014 pix_rgb  output  12  captured colour {r,g,b}, valid when de=1.
REQ-015 locked  output  1  timing matches parameters.
REQ-016 frame_start  output  1  one-clk pulse on every vs falling edge.
REQ-017 sync_err  output  1  one-clk pulse on each detected timing violation.
REQ-018 frame_crc  output  16  CRC of last complete frame; crc_valid  output  1  one-clk pulse.

Function
REQ-019 Edge detection SHALL compare current hs/vs against the value registered at the previous pix_ce.
REQ-020 hcnt (10 bit) SHALL reset to 0 on hs falling edge, else increment per pix_ce, saturating at 1023.
REQ-021 vcnt (10 bit) SHALL increment on hs falling edge and reset to 0 on vs falling edge; saturating at 1023.
REQ-022 FSM states SEARCH, TRACK, LOCKED; SEARCH -> TRACK on vs falling edge.
REQ-023 TRACK -> LOCKED on next vs falling edge if vcnt = V_TOTAL-1 and every hs falling edge in the frame saw hcnt = H_TOTAL-1; otherwise -> SEARCH.
REQ-024 In LOCKED any hs fall with hcnt != H_TOTAL-1, vs fall with vcnt != V_TOTAL-1, or saturation of hcnt/vcnt SHALL pulse sync_err and go to SEARCH.
REQ-025 locked = 1 only in state LOCKED.
REQ-026 Simultaneous hs and vs falling edges SHALL apply the hs check first, then the vs check, in the same cycle.
REQ-027 de = 1 iff LOCKED and H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
REQ-028 When de=1: x = hcnt-H_START, y = vcnt-V_START, pix_rgb = {r,g,b}; when de=0: x, y, pix_rgb hold last values.
REQ-029 x, y, de, pix_rgb SHALL be registered, updated on the pix_ce clock edge, latency 1 clk from sampling.
REQ-030 frame_start SHALL pulse on every vs falling edge regardless of state.

Reset
REQ-031 rst=0 SHALL force state SEARCH, hcnt=vcnt=0, registered hs/vs=1, all outputs 0, CRC register 16'hFFFF.
REQ-032 Deasserting rst mid-frame SHALL not assert locked before two full valid vs-to-vs frames.

Configuration
REQ-033 With VGA_RX_CRC_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_rgb of every de pixel, MSB first; on vs fall in LOCKED, frame_crc latches, crc_valid pulses, CRC re-inits.
REQ-034 Without VGA_RX_CRC_EN: frame_crc = 0, crc_valid = 0, no CRC logic.

Structure
REQ-035 Package vga_pkg SHALL hold default timing constants and the FSM state enum, shared with the vga display generator.
REQ-036 Sub-module vga_crc16 (12-bit data in, combinational next-CRC) SHALL be instantiated only under VGA_RX_CRC_EN.

Verification
REQ-037 Drive the vga display generator with digits 1..8, pix_ce every 4 clk -> locked=1 after the 2nd frame_start, no sync_err.
REQ-038 Locked stream, first active pixel -> de=1, x=0, y=0 one clk after hcnt=144, vcnt=35; last -> x=639, y=479.
REQ-039 Shorten one line to 799 pixels while locked -> single sync_err pulse, locked=0, re-lock after two good frames.
REQ-040 Hold hs high 1100 pixel clocks -> hcnt saturates at 1023, sync_err, state SEARCH.
REQ-041 Assert rst=0 mid-frame at line 200 -> all outputs 0 immediately; locked only after two full frames post-release.
REQ-042 VGA_RX_CRC_EN, constant colour 12'h000 frame -> crc_valid pulses at vs fall, frame_crc equals reference-model value; two identical frames give identical CRC.
